// File: rtl/and_chain_result_fifo.sv
// Result FIFO behind the And2 chain: buffers {O, O1} results for a
// valid/ready consumer and counts results offered while full (saturating).
module and_chain_result_fifo #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic                     in_valid,
    input  logic                     in_O,
    input  logic [1:0]               in_O1,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_WIDTH-1:0]     drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic [2:0]           mem_q [DEPTH];
    logic [2:0]           mem_d [DEPTH];

    logic push, pop;

    // Handshake flags depend only on registered occupancy, never on inputs.
    assign in_ready   = (count_q != OCC_W'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign out_data   = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign drop_count = drop_q;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through it leaves a value unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        mem_d    = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = {in_O, in_O1};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (in_valid && !in_ready && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            // NOTE: storage is cleared on reset so out_data reads a defined
            // 3'b000 afterwards; this costs a reset on every entry.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            mem_q    <= mem_d;
        end
    end

endmodule
